sta_chan_est: RTL and testbench

Parametrised spectral-temporal-averaging (STA) channel estimator. It takes one OFDM symbol of per-subcarrier raw channel estimates on an AXI-Stream input, applies a 3-tap frequency smoother, then applies first-order temporal averaging against a per-subcarrier history memory. Results go out on an AXI-Stream output. It replaces the fixed-size STA_TRFI-class estimator inside the reconfigurable estimation partition, adding configurable subcarrier count, sample width and averaging weight, a mode input, and length checking.

---
 rtl/sta_chan_est.sv | 153 +++++++++++++++
 tb/tb_sta_chan_est.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sta_chan_est.sv
// STA channel estimator: 3-tap frequency smoother followed by first-order temporal
// averaging against a per-subcarrier history, AXI-Stream in and out.
module sta_chan_est #(
   parameter int unsigned N_SC        = 52,
   parameter int unsigned DW          = 32,
   parameter int unsigned ALPHA_SHIFT = 1
) (
   input  logic            ap_clk,
   input  logic            ap_rst,
   input  logic [2*DW-1:0] in_stream_TDATA,
   input  logic            in_stream_TVALID,
   output logic            in_stream_TREADY,
   input  logic            in_stream_TLAST,
   input  logic [1:0]      mode,
   input  logic            init,
   output logic [2*DW-1:0] estStream_TDATA,
   output logic            estStream_TVALID,
   input  logic            estStream_TREADY,
   output logic            estStream_TLAST,
   output logic [31:0]     sym_count,
   output logic            len_err
);

   localparam int unsigned MW = (N_SC > 1) ? $clog2(N_SC) : 1;

   typedef enum logic [1:0] {S_FIRST = 2'd0, S_MID = 2'd1, S_FLUSH = 2'd2} t_state;

   t_state          r_state;
   logic [2*DW-1:0] r_p, r_c;
   logic [31:0]     r_idx;
   logic [1:0]      r_mode;
   logic            r_hist_valid;
   logic [2*DW-1:0] r_mem [N_SC];
   logic [2*DW-1:0] r_tdata;
   logic            r_tvalid, r_tlast, r_len_err;
   logic [31:0]     r_sym_count;

   logic            w_load, w_acc, w_emit, w_in_range;
   logic [31:0]     w_k;
   logic [MW-1:0]   w_mi;
   logic [1:0]      w_mode_in;
   logic [2*DW-1:0] w_a, w_b, w_n, w_h, w_out;

   function automatic logic [DW-1:0] f_freq(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] n);
      logic signed [DW+1:0] s;
      s = $signed({{2{a[DW-1]}}, a}) + $signed({b[DW-1], b, 1'b0}) + $signed({{2{n[DW-1]}}, n});
      s = s >>> 2;
      return s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] f_temp(input logic [DW-1:0] f, input logic [DW-1:0] h);
      logic signed [DW:0] d;
      d = $signed({f[DW-1], f}) - $signed({h[DW-1], h});
      d = d >>> ALPHA_SHIFT;
      return h + d[DW-1:0];
   endfunction

   assign w_load           = !r_tvalid || estStream_TREADY;
   assign in_stream_TREADY = !ap_rst && (r_state != S_FLUSH) && w_load;
   assign w_acc            = in_stream_TVALID && in_stream_TREADY;
   assign w_emit           = (w_acc && r_state == S_MID) || (r_state == S_FLUSH && w_load);
   assign w_mode_in        = (mode == 2'd3) ? 2'd0 : mode;

   // Output index lags the input index by one; indices past N_SC never touch history.
   assign w_k        = r_idx - 32'd1;
   assign w_in_range = (w_k < N_SC);
   assign w_mi       = w_in_range ? w_k[MW-1:0] : '0;
   assign w_h        = r_mem[w_mi];

   assign w_a = r_p;
   assign w_b = r_c;
   assign w_n = (r_state == S_FLUSH) ? r_c : in_stream_TDATA;

   always_comb begin
      logic [DW-1:0] fv;
      w_out = '0;
      for (int c = 0; c < 2; c++) begin
         fv = f_freq(w_a[c*DW +: DW], w_b[c*DW +: DW], w_n[c*DW +: DW]);
         case (r_mode)
            2'd2:    w_out[c*DW +: DW] = w_b[c*DW +: DW];
            2'd1:    w_out[c*DW +: DW] = fv;
            default: w_out[c*DW +: DW] = (r_hist_valid && w_in_range) ?
                                         f_temp(fv, w_h[c*DW +: DW]) : fv;
         endcase
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state      <= S_FIRST;
         r_p          <= '0;
         r_c          <= '0;
         r_idx        <= '0;
         r_mode       <= '0;
         r_hist_valid <= 1'b0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
         r_len_err    <= 1'b0;
         r_sym_count  <= '0;
      end else begin
         if (w_load) begin
            r_tvalid <= w_emit;
            if (w_emit) begin
               r_tdata <= w_out;
               r_tlast <= (r_state == S_FLUSH);
            end
         end
         if (w_emit && w_in_range) r_mem[w_mi] <= w_out;

         case (r_state)
            S_FIRST: if (w_acc) begin
               r_p    <= in_stream_TDATA;
               r_c    <= in_stream_TDATA;
               r_idx  <= 32'd1;
               r_mode <= w_mode_in;
               if (in_stream_TLAST) begin
                  if (N_SC != 1) r_len_err <= 1'b1;
                  r_state <= S_FLUSH;
               end else begin
                  r_state <= S_MID;
               end
            end
            S_MID: if (w_acc) begin
               r_p   <= r_c;
               r_c   <= in_stream_TDATA;
               r_idx <= r_idx + 32'd1;
               if (in_stream_TLAST) begin
                  if (r_idx + 32'd1 != N_SC) r_len_err <= 1'b1;
                  r_state <= S_FLUSH;
               end
            end
            S_FLUSH: if (w_load) begin
               r_state      <= S_FIRST;
               r_sym_count  <= r_sym_count + 32'd1;
               r_hist_valid <= 1'b1;
            end
            default: r_state <= S_FIRST;
         endcase

         // A coincident init overrides the flush setting hist_valid.
         if (init) r_hist_valid <= 1'b0;
      end
   end

   assign estStream_TDATA  = r_tdata;
   assign estStream_TVALID = r_tvalid;
   assign estStream_TLAST  = r_tlast;
   assign sym_count        = r_sym_count;
   assign len_err          = r_len_err;

endmodule

// File: tb/tb_sta_chan_est.sv
// Directed bench for sta_chan_est with N_SC=4, DW=32, ALPHA_SHIFT=1.
module tb_sta_chan_est;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [63:0] in_tdata;
   logic        in_tvalid, in_tready, in_tlast;
   logic [1:0]  mode;
   logic        init;
   logic [63:0] est_tdata;
   logic        est_tvalid, est_tready, est_tlast;
   logic [31:0] sym_count;
   logic        len_err;

   int n_chk = 0;
   int n_err = 0;
   bit stall = 1'b0;

   int si[$], sq[$], ei[$], eq[$];
   logic [63:0] out_q[$];
   bit          last_q[$];

   sta_chan_est #(.N_SC(4), .DW(32), .ALPHA_SHIFT(1)) dut (
      .ap_clk           (ap_clk),
      .ap_rst           (ap_rst),
      .in_stream_TDATA  (in_tdata),
      .in_stream_TVALID (in_tvalid),
      .in_stream_TREADY (in_tready),
      .in_stream_TLAST  (in_tlast),
      .mode             (mode),
      .init             (init),
      .estStream_TDATA  (est_tdata),
      .estStream_TVALID (est_tvalid),
      .estStream_TREADY (est_tready),
      .estStream_TLAST  (est_tlast),
      .sym_count        (sym_count),
      .len_err          (len_err)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge ap_clk) begin
      #1;
      est_tready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   always @(negedge ap_clk) begin
      if (!ap_rst && est_tvalid && est_tready) begin
         out_q.push_back(est_tdata);
         last_q.push_back(est_tlast);
      end
      if (dut.r_state == 2'd2) check("flush_in_rdy", {63'd0, in_tready}, 64'd0);
   end

   // Sends the first cnt samples of si/sq; mode m0 for sample 0, m_rest afterwards.
   task automatic send_sym(input logic [1:0] m0, input logic [1:0] m_rest, input int cnt);
      int w;
      for (int i = 0; i < cnt; i++) begin
         in_tdata  = {sq[i], si[i]};
         in_tlast  = (i == si.size() - 1);
         in_tvalid = 1'b1;
         mode      = (i == 0) ? m0 : m_rest;
         w = 0;
         @(negedge ap_clk);
         while (!in_tready && w < 100) begin
            @(negedge ap_clk);
            w++;
         end
         if (!in_tready) check("in_rdy_timeout", 64'd0, 64'd1);
         @(posedge ap_clk);
         #1;
         in_tvalid = 1'b0;
         in_tlast  = 1'b0;
      end
   endtask

   task automatic expect_sym(input string tag);
      int w;
      int n;
      logic [63:0] d;
      bit l;
      n = ei.size();
      w = 0;
      while (out_q.size() < n && w < 200) begin
         @(negedge ap_clk);
         w++;
      end
      check({tag, "_cnt"}, 64'(out_q.size()), 64'(n));
      for (int i = 0; i < n && out_q.size() > 0; i++) begin
         d = out_q.pop_front();
         l = last_q.pop_front();
         check($sformatf("%s_d%0d", tag, i), d, {eq[i], ei[i]});
         check($sformatf("%s_l%0d", tag, i), {63'd0, l}, {63'd0, (i == n - 1)});
      end
      out_q.delete();
      last_q.delete();
      @(posedge ap_clk);
      #1;
   endtask

   initial begin
      ap_rst = 1'b1; in_tdata = '0; in_tvalid = 1'b0; in_tlast = 1'b0;
      mode = 2'd0; init = 1'b0; est_tready = 1'b1;
      repeat (3) @(posedge ap_clk);
      #1;
      check("rst_tvalid", {63'd0, est_tvalid}, 64'd0);
      check("rst_tlast", {63'd0, est_tlast}, 64'd0);
      check("rst_tdata", est_tdata, 64'd0);
      check("rst_symcnt", {32'd0, sym_count}, 64'd0);
      check("rst_lenerr", {63'd0, len_err}, 64'd0);
      check("rst_in_rdy", {63'd0, in_tready}, 64'd0);
      ap_rst = 1'b0;
      @(posedge ap_clk);
      #1;

      // Fresh history: output is the smoothed value
      si = '{4, 8, 12, 16}; sq = '{0, 0, 0, 0};
      ei = '{5, 8, 12, 15}; eq = '{0, 0, 0, 0};
      send_sym(2'd0, 2'd0, si.size()); expect_sym("s1");
      check("s1_symcnt", {32'd0, sym_count}, 64'd1);
      check("s1_lenerr", {63'd0, len_err}, 64'd0);

      si = '{8, 8, 8, 8};
      ei = '{6, 8, 10, 11};
      send_sym(2'd0, 2'd0, si.size()); expect_sym("s2");
      check("s2_symcnt", {32'd0, sym_count}, 64'd2);

      @(posedge ap_clk); #1; init = 1'b1;
      @(posedge ap_clk); #1; init = 1'b0;
      si = '{-3}; sq = '{0};
      ei = '{-3}; eq = '{0};
      send_sym(2'd0, 2'd0, si.size()); expect_sym("s3");
      check("s3_lenerr", {63'd0, len_err}, 64'd1);

      // Long symbol: index 4 bypasses history, mem[0..3] updated
      si = '{0, 4, 8, 12, 16}; sq = '{0, 0, 0, 0, 0};
      ei = '{-1, 6, 9, 11, 15}; eq = '{0, 0, 0, 0, 0};
      send_sym(2'd0, 2'd0, si.size()); expect_sym("s4");
      check("s4_lenerr", {63'd0, len_err}, 64'd1);

      si = '{0, 0, 0, 0}; sq = '{0, 0, 0, 0};
      ei = '{-1, 3, 4, 5}; eq = '{0, 0, 0, 0};
      send_sym(2'd0, 2'd0, si.size()); expect_sym("s5");
      check("s5_symcnt", {32'd0, sym_count}, 64'd5);

      si = '{1, 100, 1, 100};
      ei = '{1, 100, 1, 100};
      send_sym(2'd2, 2'd2, si.size()); expect_sym("s6_byp");

      ei = '{25, 50, 50, 75};
      send_sym(2'd1, 2'd1, si.size()); expect_sym("s7_freq");
      check("s7_symcnt", {32'd0, sym_count}, 64'd7);

      stall = 1'b1;
      si = '{4, 8, 12, 16}; sq = '{-4, -8, -12, -16};
      ei = '{5, 8, 12, 15}; eq = '{-5, -8, -12, -15};
      send_sym(2'd1, 2'd1, si.size()); expect_sym("bp_a");
      si = '{1, 100, 1, 100}; sq = '{0, 0, 0, 0};
      ei = '{25, 50, 50, 75}; eq = '{0, 0, 0, 0};
      send_sym(2'd1, 2'd1, si.size()); expect_sym("bp_b");
      // Mode flips after subcarrier 0; the latched mode must persist
      si = '{-8, 0, 8, 16};
      ei = '{-6, 0, 8, 14};
      send_sym(2'd1, 2'd2, si.size()); expect_sym("bp_c");
      check("bp_symcnt", {32'd0, sym_count}, 64'd10);
      stall = 1'b0;
      mode = 2'd0;
      @(posedge ap_clk); #1;

      si = '{4, 8, 12, 16}; sq = '{0, 0, 0, 0};
      send_sym(2'd0, 2'd0, 2);
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      check("mrst_tvalid", {63'd0, est_tvalid}, 64'd0);
      check("mrst_symcnt", {32'd0, sym_count}, 64'd0);
      check("mrst_lenerr", {63'd0, len_err}, 64'd0);
      ap_rst = 1'b0;
      out_q.delete();
      last_q.delete();
      @(posedge ap_clk); #1;
      ei = '{5, 8, 12, 15}; eq = '{0, 0, 0, 0};
      send_sym(2'd0, 2'd0, si.size()); expect_sym("post_rst");
      check("post_rst_symcnt", {32'd0, sym_count}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
